// File: rtl/mi_arbiter_pkg.sv
// Shared definitions for the modularInv arbiter: default operand width and FSM states.
package mi_arbiter_pkg;

  localparam int unsigned WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mi_arbiter_if.sv
// Requester and modularInv-core signals of the arbiter, bundled with directional modports.
interface mi_arbiter_if
  import mi_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = mi_arbiter_pkg::WIDTH
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_opA;
  logic [N_REQ*WIDTH-1:0] req_opM;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic [WIDTH-1:0]       mi_opA;
  logic [WIDTH-1:0]       mi_opM;
  logic                   mi_in_valid;
  logic [WIDTH-1:0]       mi_out_data;
  logic                   mi_out_valid;

  // Arbiter side
  modport slave (
    input  req_valid, req_opA, req_opM, mi_out_data, mi_out_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, mi_opA, mi_opM, mi_in_valid
  );

  // Requesters and core side
  modport master (
    output req_valid, req_opA, req_opM, mi_out_data, mi_out_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mi_opA, mi_opM, mi_in_valid
  );

endinterface

// File: rtl/mi_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module mi_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    idx
);

  // Scan from the farthest offset down so the nearest one after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      if (req[PW'((32'(ptr) + k) % N_REQ)]) begin
        valid = 1'b1;
        idx   = PW'((32'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mi_arbiter.sv
// Round-robin sharing of one modularInv core between N_REQ requesters, with
// operand screening and a WAIT watchdog so a bad request or hung core cannot stall.
module mi_arbiter
  import mi_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WIDTH       = mi_arbiter_pkg::WIDTH,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic      clk,
  input  logic      rst_n,
  mi_arbiter_if.slave bus,
  output logic      busy
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, owner;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] cand_a, cand_m;
  logic             screen_bad;
  logic [CW-1:0]    wdog;
  logic             wdog_hit;
  logic [WIDTH-1:0] opa_q, opm_q, data_q;
  logic             err_q;
  logic [N_REQ-1:0] ready, rspv;
  logic             in_valid;

  mi_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    cand_a = '0;
    cand_m = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PW'(i) == pick_idx) begin
        cand_a = bus.req_opA[i*WIDTH +: WIDTH];
        cand_m = bus.req_opM[i*WIDTH +: WIDTH];
      end
    end
  end

  assign screen_bad = (cand_a == '0) || (cand_m < WIDTH'(2));
  assign wdog_hit   = (wdog == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    ready     = '0;
    rspv      = '0;
    in_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          ready[pick_idx] = 1'b1;
          state_nxt       = screen_bad ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        in_valid  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mi_out_valid || wdog_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rspv[owner] = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Pulses are suppressed while reset is asserted so nothing is accepted or returned then.
    if (rst_n) begin
      ready    = '0;
      rspv     = '0;
      in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= ST_IDLE;
      ptr    <= PW'(N_REQ - 1);
      owner  <= '0;
      opa_q  <= '0;
      opm_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      wdog   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            ptr   <= pick_idx;
            owner <= pick_idx;
            if (screen_bad) begin
              data_q <= '0;
              err_q  <= 1'b1;
            end else begin
              opa_q <= cand_a;
              opm_q <= cand_m;
            end
          end
        end
        ST_ISSUE: wdog <= '0;
        ST_WAIT: begin
          if (bus.mi_out_valid) begin
            data_q <= bus.mi_out_data;
            err_q  <= 1'b0;
          end else if (wdog_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.rsp_valid   = rspv;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_err     = err_q;
  assign bus.mi_opA      = opa_q;
  assign bus.mi_opM      = opm_q;
  assign bus.mi_in_valid = in_valid;
  assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_mi_arbiter.sv
// Directed bench for mi_arbiter with a small modular-inverse core model of fixed latency.
module tb_mi_arbiter;

  localparam int unsigned W = 256;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int          core_lat = 10;
  bit          core_hang = 1'b0;
  int          stray_cyc = -1;
  int          cd = 0;
  logic [31:0] cap_a, cap_m;

  mi_arbiter_if #(.N_REQ(4), .WIDTH(W)) bus ();

  mi_arbiter #(.N_REQ(4), .WIDTH(W), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inv_mod(input logic [31:0] a, input logic [31:0] m);
    for (int unsigned x = 1; x < m; x++)
      if ((a * x) % m == 1) return x;
    return '0;
  endfunction

  // Core model: result appears core_lat cycles after the in_valid cycle.
  always @(negedge clk) begin
    bus.mi_out_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.mi_out_valid = 1'b1;
        bus.mi_out_data  = W'(inv_mod(cap_a, cap_m));
      end
    end
    if (cyc == stray_cyc) begin
      bus.mi_out_valid = 1'b1;
      bus.mi_out_data  = W'(32'h55);
    end
    if (bus.mi_in_valid && !core_hang) begin
      cap_a = bus.mi_opA[31:0];
      cap_m = bus.mi_opM[31:0];
      cd    = core_lat;
    end
  end

  task automatic set_req(input int i, input int unsigned a, input int unsigned m);
    bus.req_opA[i*W +: W] = W'(a);
    bus.req_opM[i*W +: W] = W'(m);
  endtask

  task automatic wait_accept(input int limit, output int acyc, output logic [3:0] rr);
    acyc = -1;
    rr   = '0;
    for (int i = 0; i < limit; i++) begin
      if (bus.req_ready != 4'b0) begin
        acyc = cyc;
        rr   = bus.req_ready;
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_rsp(input int limit, output int rcyc, output logic [3:0] rv,
                          output logic [W-1:0] rd, output logic re, output int ivc,
                          output int ivcyc, output int rdy_cnt);
    rcyc = -1; rv = '0; rd = '1; re = 1'bx; ivc = 0; ivcyc = -1; rdy_cnt = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (bus.mi_in_valid) begin ivc++; ivcyc = cyc; end
      if (bus.req_ready != 4'b0) rdy_cnt++;
      if (bus.rsp_valid != 4'b0) begin
        rcyc = cyc; rv = bus.rsp_valid; rd = bus.rsp_data; re = bus.rsp_err;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_opA = '0;
    bus.req_opM = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", bus.req_ready); end
    total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", bus.rsp_valid); end
    total++; if (bus.mi_in_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid got=%b want=0", bus.mi_in_valid); end
    total++; if (bus.mi_opA !== W'(0) || bus.mi_opM !== W'(0)) begin bad++; $display("FAIL reset_mi_ops got=%0h/%0h want=0/0", bus.mi_opA, bus.mi_opM); end
    total++; if (bus.rsp_data !== W'(0) || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%0h/%b want=0/0", bus.rsp_data, bus.rsp_err); end
  endtask

  task automatic test_single();
    int acyc, rcyc, ivc, ivcyc, rdyc; logic [3:0] rr, rv; logic [W-1:0] rd; logic re;
    set_req(0, 3, 7);
    bus.req_valid = 4'b0001; #1;
    wait_accept(5, acyc, rr);
    total++; if (rr !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", rr); end
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (ivcyc !== acyc + 1 || ivc !== 1) begin bad++; $display("FAIL single_in_valid got=cyc%0d x%0d want=cyc%0d x1", ivcyc, ivc, acyc + 1); end
    total++; if (rcyc !== acyc + 12) begin bad++; $display("FAIL single_latency got=%0d want=%0d", rcyc, acyc + 12); end
    total++; if (rv !== 4'b0001 || rd !== W'(5) || re !== 1'b0) begin bad++; $display("FAIL single_rsp got=%b/%0h/%b want=0001/5/0", rv, rd, re); end
  endtask

  task automatic test_two_pending();
    int acyc, acyc2, rcyc, ivc, ivcyc, rdyc; logic [3:0] rr, rv; logic [W-1:0] rd; logic re;
    rst = 1'b1;
    set_req(1, 4, 11);
    set_req(3, 2, 9);
    bus.req_valid = 4'b1010;
    repeat (2) @(negedge clk); #1;
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL two_ready_in_reset got=%b want=0000", bus.req_ready); end
    rst = 1'b0; #1;
    wait_accept(5, acyc, rr);
    total++; if (rr !== 4'b0010) begin bad++; $display("FAIL two_first_grant got=%b want=0010", rr); end
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (rv !== 4'b0010 || rd !== W'(3) || re !== 1'b0) begin bad++; $display("FAIL two_rsp1 got=%b/%0h/%b want=0010/3/0", rv, rd, re); end
    total++; if (rdyc !== 0) begin bad++; $display("FAIL two_overlap got=%0d want=0", rdyc); end
    @(negedge clk); #1;
    wait_accept(5, acyc2, rr);
    total++; if (rr !== 4'b1000 || acyc2 !== rcyc + 1) begin bad++; $display("FAIL two_second_grant got=%b@%0d want=1000@%0d", rr, acyc2, rcyc + 1); end
    @(posedge clk); #1 bus.req_valid[3] = 1'b0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (rv !== 4'b1000 || rd !== W'(5) || re !== 1'b0) begin bad++; $display("FAIL two_rsp2 got=%b/%0h/%b want=1000/5/0", rv, rd, re); end
  endtask

  task automatic test_round_robin();
    int acyc, rcyc, ivc, ivcyc, rdyc; logic [3:0] rr, rv, exp_g; logic [W-1:0] rd; logic re;
    int unsigned exp_d[4] = '{7, 9, 10, 8};
    for (int i = 0; i < 4; i++) set_req(i, i + 2, 13);
    bus.req_valid = 4'b1111; #1;
    for (int k = 0; k < 12; k++) begin
      exp_g = 4'b0001 << (k % 4);
      wait_accept(5, acyc, rr);
      total++; if (rr !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, rr, exp_g); end
      @(posedge clk); #1;
      wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
      total++; if (rv !== exp_g) begin bad++; $display("FAIL rr_owner%0d got=%b want=%b", k, rv, exp_g); end
      total++; if (rd !== W'(exp_d[k % 4]) || re !== 1'b0) begin bad++; $display("FAIL rr_data%0d got=%0h/%b want=%0h/0", k, rd, re, exp_d[k % 4]); end
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
  endtask

  task automatic run_screen(input int i, input int unsigned a, input int unsigned m,
                            input logic exp_err, input int unsigned exp_d, input int exp_lat);
    int acyc, rcyc, ivc, ivcyc, rdyc; logic [3:0] rr, rv; logic [W-1:0] rd; logic re;
    set_req(i, a, m);
    bus.req_valid = 4'b0001 << i; #1;
    wait_accept(5, acyc, rr);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++;
    if (rr !== (4'b0001 << i) || rv !== (4'b0001 << i) || rcyc !== acyc + exp_lat ||
        re !== exp_err || rd !== W'(exp_d) || ivc !== (exp_err ? 0 : 1)) begin
      bad++;
      $display("FAIL screen_req%0d_a%0d_m%0d got=rdy%b rsp%b lat%0d err%b data%0h iv%0d want=lat%0d err%b data%0h",
               i, a, m, rr, rv, rcyc - acyc, re, rd, ivc, exp_lat, exp_err, exp_d);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_screen();
    int ivc = 0;
    run_screen(2, 0, 13, 1'b1, 0, 1);
    run_screen(1, 5, 1, 1'b1, 0, 1);
    run_screen(0, 1, 2, 1'b0, 1, 12);
    run_screen(3, 0, 0, 1'b1, 0, 1);
    repeat (4) begin @(negedge clk); #1; if (bus.mi_in_valid) ivc++; end
    total++; if (ivc !== 0) begin bad++; $display("FAIL screen_idle_in_valid got=%0d want=0", ivc); end
  endtask

  task automatic test_timeout();
    int acyc, rcyc, ivc, ivcyc, rdyc, ev; logic [3:0] rr, rv; logic [W-1:0] rd; logic re;
    core_hang = 1'b1;
    set_req(0, 3, 7);
    bus.req_valid = 4'b0001; #1;
    wait_accept(5, acyc, rr);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(60, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (rcyc !== acyc + 18 || ivc !== 1) begin bad++; $display("FAIL timeout_latency got=%0d iv%0d want=%0d iv1", rcyc - acyc, ivc, 18); end
    total++; if (rv !== 4'b0001 || re !== 1'b1 || rd !== W'(0)) begin bad++; $display("FAIL timeout_rsp got=%b/%b/%0h want=0001/1/0", rv, re, rd); end
    stray_cyc = cyc + 2;
    ev = 0;
    repeat (6) begin @(negedge clk); #1; if (bus.rsp_valid != 4'b0 || busy) ev++; end
    total++; if (ev !== 0) begin bad++; $display("FAIL timeout_stray got=%0d want=0", ev); end
    core_hang = 1'b0;
    set_req(1, 4, 11);
    bus.req_valid = 4'b0010; #1;
    wait_accept(5, acyc, rr);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (rv !== 4'b0010 || rd !== W'(3) || re !== 1'b0) begin bad++; $display("FAIL timeout_recover got=%b/%0h/%b want=0010/3/0", rv, rd, re); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int acyc, rcyc, ivc, ivcyc, rdyc, ev; logic [3:0] rr, rv; logic [W-1:0] rd; logic re;
    set_req(3, 2, 9);
    bus.req_valid = 4'b1000; #1;
    wait_accept(5, acyc, rr);
    @(posedge clk); #1 bus.req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_in_wait got=%b want=1", busy); end
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.mi_in_valid !== 1'b0 ||
        bus.mi_opA !== W'(0) || bus.mi_opM !== W'(0) || bus.rsp_data !== W'(0) || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs got=busy%b rdy%b rsp%b iv%b opA%0h opM%0h data%0h err%b want=all0",
               busy, bus.req_ready, bus.rsp_valid, bus.mi_in_valid, bus.mi_opA, bus.mi_opM, bus.rsp_data, bus.rsp_err);
    end
    rst = 1'b0;
    ev = 0;
    repeat (12) begin @(negedge clk); #1; if (bus.rsp_valid != 4'b0 || busy) ev++; end
    total++; if (ev !== 0) begin bad++; $display("FAIL midrst_no_rsp got=%0d want=0", ev); end
    bus.req_valid = 4'b1000; #1;
    wait_accept(5, acyc, rr);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(40, rcyc, rv, rd, re, ivc, ivcyc, rdyc);
    total++; if (rv !== 4'b1000 || rd !== W'(5) || re !== 1'b0) begin bad++; $display("FAIL midrst_rerequest got=%b/%0h/%b want=1000/5/0", rv, rd, re); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pending();
    test_round_robin();
    test_screen();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=stuck want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
